uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter OVS_DIV, default 27, meaning clk cycles per 1/16-bit oversample tick (50 MHz, 115200 baud).
REQ-002 SHALL have port clk  input  1  system clock; all flops on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock, asynchronous, active-high.
REQ-004 SHALL have port RxD  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port end_count  input  1  bit-counter-zero flag from the receiver datapath.
REQ-006 SHALL have port rxd_s  output  1  registered sampled bit, driving the datapath serial input.
REQ-007 SHALL have port load_sr  output  1  one-cycle shift strobe to the datapath.
REQ-008 SHALL have port count  output  1  one-cycle bit-counter decrement strobe.
REQ-009 SHALL have port set_count  output  1  bit-counter preset to 7.
REQ-010 SHALL have port data_ready  output  1  one-cycle pulse: datapath byte valid.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-012 SHALL pass RxD through a 2-flop synchronizer (rxd_sync); the synchronizer resets to 1.
REQ-013 SHALL generate a tick every OVS_DIV clocks from a prescaler; the prescaler and 4-bit sub-tick counter clear on entry to START.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 SHALL, in IDLE, hold set_count=1 and enter START when rxd_sync=0.
REQ-016 SHALL, in START, sample at sub-tick 8: a 0 enters DATA with the sub-tick counter cleared; a 1 (false start) returns to IDLE with no strobes.
REQ-017 SHALL, in DATA, sample every 16 ticks: register the sample into rxd_s and pulse load_sr in the same cycle.
REQ-018 SHALL, at each DATA sample, pulse count if end_count=0, or enter STOP with no count pulse if end_count=1; this yields exactly 8 load_sr and 7 count pulses per frame.
REQ-019 SHALL, in STOP, sample after 16 ticks: a 1 pulses data_ready and goes to IDLE; a 0 pulses frame_err and goes to WAIT_HIGH.
REQ-020 SHALL leave WAIT_HIGH for IDLE only when rxd_sync=1.
REQ-021 SHALL register data_ready and frame_err as exactly one clk cycle, never both together, and never assert count and set_count in the same cycle.
REQ-022 SHALL accept a start bit in the first IDLE cycle after STOP, so back-to-back frames receive with no gap.

Reset
REQ-023 SHALL on rst: state=IDLE, prescaler=0, sub-tick=0, synchronizer=11, rxd_s=1, load_sr=0, count=0, set_count=1, data_ready=0, frame_err=0.
REQ-024 SHALL abort any frame when rst asserts mid-frame; no data_ready or frame_err is produced for the aborted frame.

Configuration
REQ-025 SHALL, with macro UART_RX_GLITCH_FILTER_EN defined, take each sample as the majority of the last 3 rxd_sync values (3-bit history register, reset 111).
REQ-026 SHALL, without UART_RX_GLITCH_FILTER_EN, take each sample as rxd_sync directly, with no history register.

Verification (OVS_DIV=4, receiver datapath attached)
REQ-027 SHALL verify: frame 0xA5 8N1 -> data=0xA5, one data_ready pulse, 8 load_sr pulses, 7 count pulses, frame_err=0.
REQ-028 SHALL verify: RxD low for 3 ticks then high -> return to IDLE, zero load_sr pulses, no data_ready.
REQ-029 SHALL verify: frame 0x3C with stop bit 0 -> one frame_err pulse, no data_ready, WAIT_HIGH held until RxD=1.
REQ-030 SHALL verify: rst asserted during bit 4 of a frame -> all outputs at reset values immediately; a following frame 0x5A is received correctly.
REQ-031 SHALL verify: back-to-back frames 0x00 then 0xFF -> two data_ready pulses, with data 0x00 then 0xFF.
REQ-032 SHALL verify: frame 0x00 with a 1-clk high glitch at the bit-3 sample -> data=0x00 with UART_RX_GLITCH_FILTER_EN; data=0x08 without it.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Serial receive control bundle between the RX controller and its datapath.
// master: controller side; slave: datapath side.
interface uart_rx_ctrl_if;
    logic RxD;
    logic end_count;
    logic rxd_s;
    logic load_sr;
    logic count;
    logic set_count;
    logic data_ready;
    logic frame_err;

    modport master (
        input  RxD,
        input  end_count,
        output rxd_s,
        output load_sr,
        output count,
        output set_count,
        output data_ready,
        output frame_err
    );

    modport slave (
        output RxD,
        output end_count,
        input  rxd_s,
        input  load_sr,
        input  count,
        input  set_count,
        input  data_ready,
        input  frame_err
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// 16x-oversampled 8N1 UART receive controller driving an external datapath.
// Optional 3-sample majority filter: define UART_RX_GLITCH_FILTER_EN.
module uart_rx_ctrl #(
    parameter int unsigned OVS_DIV = 27
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_ctrl_if.master rx_io
);

    localparam int unsigned PW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(OVS_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state_q;
    logic [1:0]    sync_q;
    logic [PW-1:0] presc_q;
    logic [3:0]    sub_q;
    logic          rxd_s_q;
    logic          load_sr_q;
    logic          count_q;
    logic          set_count_q;
    logic          data_ready_q;
    logic          frame_err_q;

    logic rxd_sync;
    logic tick;
    logic sample;

    assign rxd_sync = sync_q[1];
    assign tick     = (presc_q == PRESC_MAX);

`ifdef UART_RX_GLITCH_FILTER_EN
    logic [2:0] hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 3'b111;
        end else begin
            hist_q <= {hist_q[1:0], rxd_sync};
        end
    end

    assign sample = (hist_q[0] & hist_q[1]) |
                    (hist_q[0] & hist_q[2]) |
                    (hist_q[1] & hist_q[2]);
`else
    assign sample = rxd_sync;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            presc_q      <= '0;
            sub_q        <= '0;
            rxd_s_q      <= 1'b1;
            load_sr_q    <= 1'b0;
            count_q      <= 1'b0;
            set_count_q  <= 1'b1;
            data_ready_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], rx_io.RxD};
            load_sr_q    <= 1'b0;
            count_q      <= 1'b0;
            data_ready_q <= 1'b0;
            frame_err_q  <= 1'b0;
            presc_q      <= tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                sub_q <= sub_q + 4'd1;
            end

            unique case (state_q)
                IDLE: begin
                    set_count_q <= 1'b1;
                    if (!rxd_sync) begin
                        state_q     <= START;
                        presc_q     <= '0;
                        sub_q       <= '0;
                        set_count_q <= 1'b0;
                    end
                end
                // Mid start bit: re-check the line to reject noise.
                START: begin
                    if (tick && sub_q == 4'd7) begin
                        sub_q <= '0;
                        if (!sample) begin
                            state_q <= DATA;
                        end else begin
                            state_q     <= IDLE;
                            set_count_q <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick && sub_q == 4'd15) begin
                        rxd_s_q   <= sample;
                        load_sr_q <= 1'b1;
                        if (rx_io.end_count) begin
                            state_q <= STOP;
                        end else begin
                            count_q <= 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick && sub_q == 4'd15) begin
                        if (sample) begin
                            data_ready_q <= 1'b1;
                            state_q      <= IDLE;
                            set_count_q  <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rxd_sync) begin
                        state_q     <= IDLE;
                        set_count_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    set_count_q <= 1'b1;
                end
            endcase
        end
    end

    assign rx_io.rxd_s      = rxd_s_q;
    assign rx_io.load_sr    = load_sr_q;
    assign rx_io.count      = count_q;
    assign rx_io.set_count  = set_count_q;
    assign rx_io.data_ready = data_ready_q;
    assign rx_io.frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl with an attached shift-register/bit-counter datapath.
// Frames are driven as ideal 8N1 waveforms at 16*OVS_DIV clocks per bit.
module tb_uart_rx_ctrl;

    localparam int OVS = 4;
    localparam int BIT = 16 * OVS;

    logic clk;
    logic rst;
    logic line;
    logic glitch;

    uart_rx_ctrl_if rx_if ();

    uart_rx_ctrl #(.OVS_DIV(OVS)) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_io (rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] sr;
    logic [2:0] bitcnt;

    initial begin
        sr     = 8'h00;
        bitcnt = 3'd7;
    end

    assign rx_if.RxD       = line | glitch;
    assign rx_if.end_count = (bitcnt == 3'd0);

    always @(posedge clk) begin
        if (rx_if.set_count) bitcnt <= 3'd7;
        else if (rx_if.count) bitcnt <= bitcnt - 3'd1;
        if (rx_if.load_sr) sr <= {rx_if.rxd_s, sr[7:1]};
    end

    int n_load = 0;
    int n_cnt = 0;
    int n_rdy = 0;
    int n_ferr = 0;
    int n_both = 0;
    int n_cs = 0;
    logic [7:0] data_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_if.load_sr) n_load++;
            if (rx_if.count) n_cnt++;
            if (rx_if.frame_err) n_ferr++;
            if (rx_if.data_ready) begin
                n_rdy++;
                data_q.push_back(sr);
            end
            if (rx_if.data_ready && rx_if.frame_err) n_both++;
            if (rx_if.count && rx_if.set_count) n_cs++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        line = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input int nclk);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10 * BIT; i++) begin
            if (i >= nclk) break;
            line = f[i / BIT];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop(output logic [7:0] d);
        if (data_q.size() > 0) d = data_q.pop_front();
        else d = 8'hxx;
    endtask

    task automatic glitch_at_bit3(output bit seen);
        int pulses;
        pulses = 0;
        seen = 0;
        for (int i = 0; i < 12 * BIT; i++) begin
            @(negedge clk);
            if (rx_if.load_sr) pulses++;
            if (pulses == 3) begin
                seen = 1;
                break;
            end
        end
        if (seen) begin
            repeat (BIT - 3) @(posedge clk);
            #1 glitch = 1'b1;
            @(posedge clk);
            #1 glitch = 1'b0;
        end
    endtask

    initial begin
        int l0, c0, r0, f0;
        logic [7:0] d;
        logic [7:0] exp_b;
        bit seen;

        rst = 1'b1;
        line = 1'b1;
        glitch = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rxd_s", rx_if.rxd_s, 1);
        chk("rst_load_sr", rx_if.load_sr, 0);
        chk("rst_count", rx_if.count, 0);
        chk("rst_set_count", rx_if.set_count, 1);
        chk("rst_data_ready", rx_if.data_ready, 0);
        chk("rst_frame_err", rx_if.frame_err, 0);
        rst = 1'b0;
        idle(20);

        l0 = n_load; c0 = n_cnt; r0 = n_rdy; f0 = n_ferr;
        send(8'hA5, 1'b1, 10 * BIT);
        idle(20);
        pop(d);
        chk("a5_data", d, 8'hA5);
        chk("a5_ready", n_rdy - r0, 1);
        chk("a5_load", n_load - l0, 8);
        chk("a5_count", n_cnt - c0, 7);
        chk("a5_ferr", n_ferr - f0, 0);

        l0 = n_load; r0 = n_rdy;
        line = 1'b0;
        repeat (3 * OVS) begin
            @(posedge clk);
            #1;
        end
        idle(2 * BIT);
        chk("false_load", n_load - l0, 0);
        chk("false_ready", n_rdy - r0, 0);
        chk("false_idle", rx_if.set_count, 1);

        l0 = n_load; r0 = n_rdy; f0 = n_ferr;
        send(8'h3C, 1'b0, 10 * BIT);
        line = 1'b0;
        repeat (4 * BIT) begin
            @(posedge clk);
            #1;
        end
        chk("ferr_pulse", n_ferr - f0, 1);
        chk("ferr_ready", n_rdy - r0, 0);
        chk("ferr_load", n_load - l0, 8);
        chk("ferr_wait_high", rx_if.set_count, 0);
        idle(10);
        chk("ferr_released", rx_if.set_count, 1);
        idle(2 * BIT);

        l0 = n_load; r0 = n_rdy; f0 = n_ferr;
        send(8'h96, 1'b1, 5 * BIT + 20);
        chk("abort_mid_frame", n_load - l0, 4);
        #2 rst = 1'b1;
        #1;
        chk("abort_rxd_s", rx_if.rxd_s, 1);
        chk("abort_load_sr", rx_if.load_sr, 0);
        chk("abort_count", rx_if.count, 0);
        chk("abort_set_count", rx_if.set_count, 1);
        chk("abort_data_ready", rx_if.data_ready, 0);
        chk("abort_frame_err", rx_if.frame_err, 0);
        line = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2 * BIT);
        chk("abort_no_ready", n_rdy - r0, 0);
        chk("abort_no_ferr", n_ferr - f0, 0);
        send(8'h5A, 1'b1, 10 * BIT);
        idle(20);
        pop(d);
        chk("after_rst_data", d, 8'h5A);
        chk("after_rst_ready", n_rdy - r0, 1);

        r0 = n_rdy;
        send(8'h00, 1'b1, 10 * BIT);
        send(8'hFF, 1'b1, 10 * BIT);
        idle(20);
        chk("b2b_ready", n_rdy - r0, 2);
        pop(d);
        chk("b2b_first", d, 8'h00);
        pop(d);
        chk("b2b_second", d, 8'hFF);

        seen = 0;
        fork
            send(8'h00, 1'b1, 10 * BIT);
            glitch_at_bit3(seen);
        join
        idle(20);
        chk("glitch_found_bit3", seen, 1);
`ifdef UART_RX_GLITCH_FILTER_EN
        exp_b = 8'h00;
`else
        exp_b = 8'h08;
`endif
        pop(d);
        chk("glitch_data", d, exp_b);

        for (int k = 0; k < 5; k++) begin
            exp_b = 8'($urandom_range(0, 255));
            l0 = n_load; c0 = n_cnt; r0 = n_rdy;
            send(exp_b, 1'b1, 10 * BIT);
            idle($urandom_range(0, 30));
            pop(d);
            chk("rand_data", d, exp_b);
            chk("rand_pulses", (n_load - l0) * 256 + (n_cnt - c0) * 16 + (n_rdy - r0),
                8 * 256 + 7 * 16 + 1);
        end

        idle(20);
        chk("never_ready_and_ferr", n_both, 0);
        chk("never_count_and_set", n_cs, 0);
        chk("no_stray_data", data_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
